// File: rtl/toggle_rx_pkg.sv
// Shared constants for the toggle-line receiver: default widths, warm-up
// state encoding and the all-ones saturation constant.
package toggle_rx_pkg;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  localparam logic [0:0] ST_WARM = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Wide all-ones value; users truncate it to their own accumulator width.
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/toggle_rx_if.sv
// Count delivery slot. The producer raises cnt_valid with cnt_data/cnt_ovf
// stable until a cycle where cnt_ready is also high; that cycle is the transfer.
interface toggle_rx_if
  import toggle_rx_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             cnt_valid;
    logic             cnt_ready;
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_ovf;

    modport master(output cnt_valid, output cnt_data, output cnt_ovf, input cnt_ready);
    modport slave(input cnt_valid, input cnt_data, input cnt_ovf, output cnt_ready);

endinterface

// File: rtl/toggle_rx_sync_chain.sv
// Plain multi-flop synchroniser for a single asynchronous bit; shared by
// several receivers.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/toggle_rx.sv
// Toggle-line event receiver: synchronise, edge-detect into one-cycle pulses,
// accumulate events and hand batches out through a valid/ready count slot.
module toggle_rx
  import toggle_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       t_in,
    output logic       level,
    output logic       pulse,
    output logic [0:0] state,
    toggle_rx_if.master cnt
);

    localparam logic [CNT_W-1:0] ACC_MAX   = CNT_MAX[CNT_W-1:0];
    localparam logic [2:0]       WARM_LAST = 3'(SYNC_STAGES);

    logic             prev;
    logic [2:0]       warm_cnt;
    logic             armed;
    logic             ev;
    logic             slot_free;
    logic [CNT_W-1:0] acc;
    logic             sat;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (t_in),
        .q    (level)
    );

    // Warm-up masks the chain filling from zero, so a line already high at
    // reset release is not mistaken for an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WARM;
            warm_cnt <= '0;
        end else if (state == ST_WARM) begin
            if (warm_cnt == WARM_LAST) begin
                state <= ST_RUN;
            end else begin
                warm_cnt <= warm_cnt + 3'd1;
            end
        end
    end

    assign armed     = (state == ST_RUN);
    assign ev        = armed & en & (level ^ prev);
    assign slot_free = ~cnt.cnt_valid | cnt.cnt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev          <= 1'b0;
            pulse         <= 1'b0;
            acc           <= '0;
            sat           <= 1'b0;
            cnt.cnt_valid <= 1'b0;
            cnt.cnt_data  <= '0;
            cnt.cnt_ovf   <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= ev;
            if (slot_free && (acc != '0)) begin
                // An event on the transfer edge opens the next batch.
                cnt.cnt_data  <= acc;
                cnt.cnt_ovf   <= sat;
                cnt.cnt_valid <= 1'b1;
                acc           <= ev ? CNT_W'(1) : '0;
                sat           <= 1'b0;
            end else begin
                if (slot_free) begin
                    cnt.cnt_valid <= 1'b0;
                end
                if (ev) begin
                    if (acc == ACC_MAX) begin
                        sat <= 1'b1;
                    end else begin
                        acc <= acc + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_toggle_rx.sv
// Bench for toggle_rx: two instances (8-bit/2-stage and 4-bit/3-stage) share
// stimulus and are compared each cycle against a batch-level event model.
module tb_toggle_rx;
  import toggle_rx_pkg::*;

  localparam int S_A = 2;
  localparam int W_A = 8;
  localparam int S_B = 3;
  localparam int W_B = 4;

  // clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic t_in = 1'b0;
  logic cnt_ready = 1'b0;
  always #5 clk = ~clk;

  logic       level_a, pulse_a, level_b, pulse_b;
  logic [0:0] state_a, state_b;

  toggle_rx_if #(.CNT_W(W_A)) if_a ();
  toggle_rx_if #(.CNT_W(W_B)) if_b ();
  assign if_a.cnt_ready = cnt_ready;
  assign if_b.cnt_ready = cnt_ready;

  toggle_rx #(.SYNC_STAGES(S_A), .CNT_W(W_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .t_in(t_in),
    .level(level_a), .pulse(pulse_a), .state(state_a), .cnt(if_a.master)
  );

  toggle_rx #(.SYNC_STAGES(S_B), .CNT_W(W_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .t_in(t_in),
    .level(level_b), .pulse(pulse_b), .state(state_b), .cnt(if_b.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: scheduled event edges per instance, events since the
  // last transfer, and the contents of the delivery slot
  int cyc = 0;
  int m_rel = 0;
  int sched_a[$];
  int sched_b[$];
  int stg[2]  = '{S_A, S_B};
  int cmax[2] = '{(1 << W_A) - 1, (1 << W_B) - 1};
  int m_n[2];
  bit m_valid[2];
  int m_data[2];
  bit m_ovf[2];
  bit m_pulse[2];

  task automatic slot_step(input int k, input bit ev);
    bit free;
    free = !m_valid[k] || cnt_ready;
    m_pulse[k] = ev;
    if (free && m_n[k] > 0) begin
      m_data[k]  = (m_n[k] > cmax[k]) ? cmax[k] : m_n[k];
      m_ovf[k]   = (m_n[k] > cmax[k]);
      m_valid[k] = 1'b1;
      m_n[k]     = ev ? 1 : 0;
    end else begin
      if (free) m_valid[k] = 1'b0;
      m_n[k] += ev ? 1 : 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit ev_a, ev_b;
    if (!rst_n) begin
      m_rel = 0;
      sched_a.delete();
      sched_b.delete();
      for (int k = 0; k < 2; k++) begin
        m_n[k] = 0; m_valid[k] = 0; m_data[k] = 0; m_ovf[k] = 0; m_pulse[k] = 0;
      end
    end else begin
      cyc++;
      ev_a = 1'b0;
      ev_b = 1'b0;
      while (sched_a.size() > 0 && sched_a[0] < cyc) void'(sched_a.pop_front());
      if (sched_a.size() > 0 && sched_a[0] == cyc) begin
        void'(sched_a.pop_front());
        ev_a = 1'b1;
      end
      while (sched_b.size() > 0 && sched_b[0] < cyc) void'(sched_b.pop_front());
      if (sched_b.size() > 0 && sched_b[0] == cyc) begin
        void'(sched_b.pop_front());
        ev_b = 1'b1;
      end
      slot_step(0, ev_a && en && (m_rel >= stg[0] + 1));
      slot_step(1, ev_b && en && (m_rel >= stg[1] + 1));
      m_rel++;
    end
  end

  // scoreboard: outputs compared every cycle away from the active edge
  always @(negedge clk) begin
    check("a_pulse", pulse_a, m_pulse[0]);
    check("a_valid", if_a.cnt_valid, m_valid[0]);
    if (m_valid[0]) begin
      check("a_data", if_a.cnt_data, m_data[0]);
      check("a_ovf", if_a.cnt_ovf, m_ovf[0]);
    end
    check("b_pulse", pulse_b, m_pulse[1]);
    check("b_valid", if_b.cnt_valid, m_valid[1]);
    if (m_valid[1]) begin
      check("b_data", if_b.cnt_data, m_data[1]);
      check("b_ovf", if_b.cnt_ovf, m_ovf[1]);
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle();
    t_in = ~t_in;
    sched_a.push_back(cyc + 1 + S_A);
    sched_b.push_back(cyc + 1 + S_B);
  endtask

  initial begin
    int gap;
    t_in = 1'b1;
    en = 1'b1;
    cnt_ready = 1'b1;
    cycles(3);
    check("rst_state_a", state_a, ST_WARM);
    check("rst_level_a", level_a, 0);

    // source already high at reset release
    rst_n = 1'b1;
    cycles(10);
    check("warm_state_a", state_a, ST_RUN);
    check("warm_state_b", state_b, ST_RUN);
    check("warm_level_a", level_a, 1);
    check("warm_level_b", level_b, 1);

    // basic path
    for (int i = 0; i < 3; i++) begin
      toggle();
      cycles(4);
    end
    cycles(6);

    // backpressure
    cnt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      toggle();
      cycles(3);
    end
    cycles(6);
    check("bp_held_a", if_a.cnt_data, 1);
    cnt_ready = 1'b1;
    cycles(8);

    // collision: fourth event lands on the edge that transfers acc=2 in dut_a
    cnt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      toggle();
      cycles(3);
    end
    toggle();
    cycles(2);
    cnt_ready = 1'b1;
    cycles(1);
    check("coll_data_a", if_a.cnt_data, 2);
    cycles(1);
    check("coll_next_a", if_a.cnt_data, 1);
    cycles(6);

    // saturation
    cnt_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      toggle();
      cycles(2);
    end
    cycles(6);
    check("sat_first_b", if_b.cnt_data, 1);
    check("sat_first_ovf_b", if_b.cnt_ovf, 0);
    cnt_ready = 1'b1;
    cycles(1);
    check("sat_data_b", if_b.cnt_data, 15);
    check("sat_ovf_b", if_b.cnt_ovf, 1);
    check("sat_data_a", if_a.cnt_data, 19);
    check("sat_ovf_a", if_a.cnt_ovf, 0);
    cycles(4);

    // enable low discards events
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      toggle();
      cycles(3);
    end
    cycles(6);
    en = 1'b1;
    cycles(6);

    // reset with a beat pending
    cnt_ready = 1'b0;
    toggle();
    cycles(6);
    check("pre_rst_valid_a", if_a.cnt_valid, 1);
    check("pre_rst_level_a", level_a, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid_a", if_a.cnt_valid, 0);
    check("mid_rst_data_a", if_a.cnt_data, 0);
    check("mid_rst_valid_b", if_b.cnt_valid, 0);
    check("mid_rst_level_a", level_a, 0);
    check("mid_rst_level_b", level_b, 0);
    check("mid_rst_state_a", state_a, ST_WARM);
    cycles(2);
    rst_n = 1'b1;
    cnt_ready = 1'b1;
    cycles(2);
    check("rewarm_state_a", state_a, ST_WARM);
    check("rewarm_state_b", state_b, ST_WARM);
    cycles(8);
    check("rerun_state_a", state_a, ST_RUN);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      toggle();
      gap = $urandom_range(2, 6);
      for (int j = 0; j < gap; j++) begin
        @(negedge clk);
        cnt_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) en = ~en;
      end
    end

    en = 1'b1;
    cnt_ready = 1'b1;
    cycles(12);
    check("drain_valid_a", if_a.cnt_valid, 0);
    check("drain_valid_b", if_b.cnt_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/toggle_rx.md
# toggle_rx

Receive side of a toggle-encoded event line of the kind our T latch drives. A remote domain flips `t_in` once per event; this block synchronises the line into the `clk` domain, turns each transition into a one-cycle `pulse`, and accumulates events into a count. The count is delivered through a valid/ready slot with a saturation flag. It sits at the boundary of any block that consumes events from a toggling source in another domain.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on `t_in`; legal values are 2 to 4.
- `CNT_W`, default 8: width of the accumulator and of `cnt_data`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: event enable. Transitions seen while low are discarded.
- `t_in` in 1: asynchronous toggle line. Each transition is one event.
- `level` out 1: synchronised value of `t_in` (last sync stage).
- `pulse` out 1: registered; high for exactly one cycle per accepted event.
- `cnt_valid` out 1: output slot holds a count.
- `cnt_ready` in 1: consumer accepts the slot.
- `cnt_data` out `CNT_W`: number of events in the delivered batch. Never 0 while `cnt_valid` is high.
- `cnt_ovf` out 1: qualified by `cnt_valid`. Set when the batch saturated.

## Operation
- **Sync chain:** `t_in` passes through `SYNC_STAGES` flops. `prev` captures `level` every cycle.
- **Event condition:** `ev = armed & en & (level ^ prev)`.
- **Warm-up state machine, two states:**
  - WARM: a counter counts `SYNC_STAGES+1` cycles after reset release; `ev` is forced to 0.
  - RUN: entered after the warm-up count; left only by reset.
  - Effect: a `t_in` that is already high at reset release produces no event.
- **`en` low:** `prev` keeps tracking `level`, so raising `en` never creates a stale event.
- **Accumulator `acc`** (`CNT_W` bits) plus sticky `sat`:
  - On `ev`, `acc` increments.
  - If `acc` is already all-ones, it holds and `sat` is set.
- **Output slot:** the slot is free when `cnt_valid==0` or `cnt_ready==1`. Rules at each edge:
  - Slot free and `acc!=0`: load `cnt_data<=acc`, `cnt_ovf<=sat`, `cnt_valid<=1`. In the same edge, `acc<=ev?1:0` and `sat<=0`. An event arriving on the transfer edge lands in the new batch and is never lost or double-counted.
  - Slot free and `acc==0`: `cnt_valid<=0`.
  - Otherwise: the slot holds. `cnt_data` and `cnt_ovf` stay stable while `cnt_valid & ~cnt_ready`.
- **`cnt_ready` high with `cnt_valid` low** has no effect.

## Timing
- **Reset values:** every flop returns to 0 asynchronously on `rst_n` low, mid-operation included. This covers the sync chain, `prev`, state (back to WARM), `acc`, `sat`, `pulse`, `level=0`, `cnt_valid=0`, `cnt_data=0` and `cnt_ovf=0`. A pending slot is discarded.
- **Event latency:** a `t_in` transition meeting setup before edge E appears on `level` after edge E+`SYNC_STAGES`-1. `pulse` is high in the cycle after edge E+`SYNC_STAGES`, and `acc` updates on that same edge.
- **Count latency:** `cnt_valid` rises one edge after `pulse` rises, provided the slot is free.
- **Rate limit:** transitions closer together than 1 cycle plus the sync uncertainty may merge. The source must hold each level for at least 2 `clk` cycles; `pulse` can then fire on back-to-back cycles.
- **Saturation:** `cnt_data` = 2^`CNT_W`-1 with `cnt_ovf=1` means "at least that many" events.

## Structure
- Package `toggle_rx_pkg` holds the default `CNT_W`, the default `SYNC_STAGES`, the warm-up state encoding (`ST_WARM`, `ST_RUN`) and the all-ones `CNT_MAX` constant.
- Sub-module `sync_chain`: `SYNC_STAGES`-deep flop chain with async active-low reset. It is shared with other receivers.
- The top level contains the warm-up FSM, edge detect, accumulator and output slot.

## Test plan
- **Reset-high source:** hold `t_in=1` through reset release and wait 10 cycles → `pulse` stays 0 and `cnt_valid` stays 0.
- **Basic path:** after warm-up, toggle `t_in` 3 times spaced 4 cycles apart, with `cnt_ready=1` → 3 `pulse`s, each `SYNC_STAGES`+1 edges after its toggle. Three `cnt_valid` beats arrive, each with `cnt_data=1`.
- **Backpressure:** hold `cnt_ready=0` and toggle 5 times → the first beat shows `cnt_data=1` held stable. Raising `cnt_ready` yields that beat, then one beat with `cnt_data=4`, then `cnt_valid=0`.
- **Collision:** an event's `ev` coincides with a slot transfer of `acc=2` → the delivered batch is 2 and the next batch is 1, for 3 events in total.
- **Saturation:** with `CNT_W=4` and `cnt_ready=0`, send 20 events → the first beat is `cnt_data=1`, `cnt_ovf=0`. The next beat is `cnt_data=15`, `cnt_ovf=1`.
- **Enable and reset:** toggle with `en=0` → no `pulse`, and raising `en` emits nothing. Assert `rst_n` low while `cnt_valid=1` → all outputs are 0 immediately, and the FSM re-runs warm-up.
